// File: rtl/sad_accumulator.sv
// Sums ROWS beats of 8 absolute differences into one candidate SAD and tracks
// the minimum SAD and its index over NUM_CAND consecutive candidates.
module sad_accumulator #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned NUM_CAND  = 25,
  parameter int unsigned SADWIDTH  = DATAWIDTH + 3 + $clog2(ROWS),
  parameter int unsigned IDXWIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 search_start,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] ad_0,
  input  logic [DATAWIDTH-1:0] ad_1,
  input  logic [DATAWIDTH-1:0] ad_2,
  input  logic [DATAWIDTH-1:0] ad_3,
  input  logic [DATAWIDTH-1:0] ad_4,
  input  logic [DATAWIDTH-1:0] ad_5,
  input  logic [DATAWIDTH-1:0] ad_6,
  input  logic [DATAWIDTH-1:0] ad_7,
  output logic [SADWIDTH-1:0]  sad,
  output logic [IDXWIDTH-1:0]  sad_idx,
  output logic                 sad_valid,
  output logic [SADWIDTH-1:0]  best_sad,
  output logic [IDXWIDTH-1:0]  best_idx,
  output logic                 best_valid,
  output logic                 busy
);

  localparam int unsigned RSW = DATAWIDTH + 3;
  localparam int unsigned RCW = $clog2(ROWS);
  localparam logic [RCW-1:0]      LAST_ROW  = RCW'(ROWS - 1);
  localparam logic [IDXWIDTH-1:0] LAST_CAND = IDXWIDTH'(NUM_CAND - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [RCW-1:0]      row_cnt;
  logic [IDXWIDTH-1:0] cand_cnt;
  logic                all_in;

  logic                s1_valid;
  logic                s1_first;
  logic                s1_last;
  logic [RSW-1:0]      s1_rowsum;
  logic [IDXWIDTH-1:0] s1_idx;

  logic [SADWIDTH-1:0] acc;

  logic [RSW-1:0] sum01, sum23, sum45, sum67, sum0123, sum4567, rowsum;

  logic                accept;
  logic [RCW-1:0]      eff_row;
  logic [IDXWIDTH-1:0] eff_cand;
  logic [SADWIDTH-1:0] acc_sum;

  always_comb begin
    sum01   = RSW'(ad_0) + RSW'(ad_1);
    sum23   = RSW'(ad_2) + RSW'(ad_3);
    sum45   = RSW'(ad_4) + RSW'(ad_5);
    sum67   = RSW'(ad_6) + RSW'(ad_7);
    sum0123 = sum01 + sum23;
    sum4567 = sum45 + sum67;
    rowsum  = sum0123 + sum4567;
  end

  // A row arriving with search_start belongs to the new search, so the
  // counters it sees are forced to zero rather than taken from the old search.
  always_comb begin
    accept   = in_valid && (search_start || (state == RUN && !all_in));
    eff_row  = search_start ? '0 : row_cnt;
    eff_cand = search_start ? '0 : cand_cnt;
    acc_sum  = (s1_first ? '0 : acc) + SADWIDTH'(s1_rowsum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      row_cnt    <= '0;
      cand_cnt   <= '0;
      all_in     <= 1'b0;
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      s1_rowsum  <= '0;
      s1_idx     <= '0;
      acc        <= '0;
      sad        <= '0;
      sad_idx    <= '0;
      sad_valid  <= 1'b0;
      best_sad   <= '0;
      best_idx   <= '0;
      best_valid <= 1'b0;
    end else begin
      sad_valid  <= 1'b0;
      best_valid <= 1'b0;
      s1_valid   <= accept;

      if (search_start) begin
        state    <= RUN;
        busy     <= 1'b1;
        row_cnt  <= '0;
        cand_cnt <= '0;
        all_in   <= 1'b0;
        acc      <= '0;
        best_sad <= '1;
        best_idx <= '0;
      end

      if (accept) begin
        s1_rowsum <= rowsum;
        s1_first  <= (eff_row == '0);
        s1_last   <= (eff_row == LAST_ROW);
        s1_idx    <= eff_cand;
        row_cnt   <= eff_row + RCW'(1);
        if (eff_row == LAST_ROW) begin
          cand_cnt <= eff_cand + IDXWIDTH'(1);
          all_in   <= (eff_cand == LAST_CAND);
        end
      end

      if (s1_valid && !search_start) begin
        acc <= acc_sum;
        if (s1_last) begin
          sad       <= acc_sum;
          sad_idx   <= s1_idx;
          sad_valid <= 1'b1;
        end
      end

      // Strict less-than keeps the earlier candidate on a tie.
      if (sad_valid && state == RUN && !search_start) begin
        if (sad < best_sad) begin
          best_sad <= sad;
          best_idx <= sad_idx;
        end
        if (sad_idx == LAST_CAND) begin
          best_valid <= 1'b1;
          state      <= DONE;
          busy       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/sad_accumulator.md
Name: sad_accumulator

Overview:
- Downstream consumer of the 8-lane absolute-difference stage in the FME datapath.
- Each accepted beat carries one row of 8 absolute differences. The block sums ROWS beats into one candidate SAD and emits it.
- Over NUM_CAND consecutive candidates it tracks the minimum SAD and its candidate index. At the end it reports the best match to the motion-vector decision logic.

Parameters:
- DATAWIDTH, 8, width of each absolute-difference lane.
- ROWS, 8, rows (beats) per candidate block; must be a power of two, at least 2.
- NUM_CAND, 25, candidates per search; must be at least 1.
- SADWIDTH, DATAWIDTH+3+log2(ROWS) (14 at defaults), SAD and accumulator width.
- IDXWIDTH, 5, candidate index width; must satisfy 2^IDXWIDTH >= NUM_CAND.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- search_start  input  1  one-cycle pulse; clears all state and begins a search.
- in_valid  input  1  ad_0..ad_7 hold a valid row this cycle; no backpressure, the block is always ready.
- ad_0 .. ad_7  input  DATAWIDTH each  absolute-difference lanes from the upstream stage.
- sad  output  SADWIDTH  SAD of the most recently completed candidate.
- sad_idx  output  IDXWIDTH  index of that candidate.
- sad_valid  output  1  one-cycle pulse; sad and sad_idx are new.
- best_sad  output  SADWIDTH  minimum SAD found in the search.
- best_idx  output  IDXWIDTH  index of the minimum.
- best_valid  output  1  one-cycle pulse; the search is complete.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (rst=1 at an edge): all registers clear to 0, state goes to IDLE, and every output is 0. The same applies when rst is asserted mid-search: partial sums are discarded and no pulse is emitted.
- States:
  - IDLE -> RUN on search_start.
  - RUN -> DONE when the SAD of candidate NUM_CAND-1 is compared.
  - DONE -> RUN on search_start.
  - DONE holds best_sad and best_idx until the next search_start or rst.
- search_start in any state, including mid-RUN:
  - clears the row counter, candidate counter, accumulator and pipeline valids;
  - sets best_sad to all-ones;
  - sets best_idx to 0.
  - If in_valid is high in the same cycle, that row is accepted as row 0 of candidate 0 of the new search.
- in_valid is ignored in IDLE and DONE, unless it arrives in the same cycle as search_start.
- Pipeline stage 1, at the acceptance edge:
  - rowsum is the sum of the 8 lanes, computed as an unsigned (DATAWIDTH+3)-bit add tree;
  - rowsum is registered together with a valid bit and a last-row flag (row counter == ROWS-1).
- Pipeline stage 2, one edge later:
  - acc <= (first row ? 0 : acc) + rowsum, zero-extended to SADWIDTH;
  - on the last row, sad <= the final sum, sad_idx <= the candidate counter, and sad_valid pulses;
  - the accumulator then restarts for the next candidate.
- Latency: the last row is accepted at edge t; sad/sad_valid update at edge t+1; best_sad/best_idx update at edge t+2.
- Compare: when sad_valid is high and sad < best_sad (strict), best_sad/best_idx take sad/sad_idx. On a tie the earlier candidate is kept.
- best_valid pulses at the same edge as the final compare (edge t+2 of candidate NUM_CAND-1). best_sad/best_idx are final at that point.
- Row counter wraps from ROWS-1 to 0. The candidate counter increments per completed candidate and does not wrap within a search.
- Gaps in in_valid are allowed at any point. The pipeline advances only on valid beats; idle cycles neither add to nor corrupt acc.
- Arithmetic never overflows: the maximum SAD, ROWS*8*(2^DATAWIDTH-1), fits in SADWIDTH.
- busy = 1 exactly while the state is RUN.

Test Plan:
- Full-scale candidate: rst, then search_start, then 8 back-to-back rows with all lanes = 1 → sad=64, sad_idx=0, sad_valid one cycle after the last-row edge. Repeat with all lanes = 255 → sad=16320 with no overflow.
- Minimum tracking: NUM_CAND=25 with candidate k lanes = |12-k| → best_sad=0, best_idx=12, best_valid a single pulse 2 edges after the last row, state DONE, busy=0.
- Tie: candidates 3 and 7 both have SAD 40 and all others are larger → best_idx=3.
- Bubbles: random in_valid gaps inserted into the directed patterns above → identical sad, sad_idx and best results; sad_valid count equals 25.
- Restart and reset: search_start issued at row 4 of candidate 10 → the new search starts clean and best_idx reflects only the new search. rst asserted mid-RUN → all outputs 0, no pulses, state IDLE.
- search_start together with in_valid: a row presented in the same cycle is counted as row 0 (check with ROWS rows of 2 → sad=128). in_valid while IDLE or DONE is ignored.
